// File: rtl/pocket_scheduler_if.sv
// Signal bundle between the ball-physics/game-state logic and pocket_scheduler.
// The master drives frame start, ball positions and clear; the slave returns pocket results.
interface pocket_scheduler_if #(
  parameter int NUM_BALLS = 16
);
  logic                    startOfFrame;
  logic [11*NUM_BALLS-1:0] ballsTopLeftX;
  logic [11*NUM_BALLS-1:0] ballsTopLeftY;
  logic [NUM_BALLS-1:0]    ballsActive;
  logic                    clearPocketed;
  logic [NUM_BALLS-1:0]    pocketed;
  logic                    pocketValid;
  logic [3:0]              pocketBall;
  logic [2:0]              pocketHole;
  logic                    busy;
  logic                    frameDone;

  modport master (
    output startOfFrame, ballsTopLeftX, ballsTopLeftY, ballsActive, clearPocketed,
    input  pocketed, pocketValid, pocketBall, pocketHole, busy, frameDone
  );

  modport slave (
    input  startOfFrame, ballsTopLeftX, ballsTopLeftY, ballsActive, clearPocketed,
    output pocketed, pocketValid, pocketBall, pocketHole, busy, frameDone
  );
endinterface

// File: rtl/pocket_scheduler.sv
// Once-per-frame pocket detector: walks every (ball, hole) pair through one shared
// squared-distance comparator, one pair per clock, and reports new pockets as pulses.
module pocket_scheduler #(
  parameter int NUM_BALLS    = 16,
  parameter int TABLE_LEFT   = 10,
  parameter int TABLE_RIGHT  = 598,
  parameter int TABLE_TOP    = 30,
  parameter int TABLE_BOTTOM = 418,
  parameter int HOLE_HALF    = 16,
  parameter int BALL_HALF    = 16,
  parameter int POCKET_R     = 12
) (
  input  logic               clk,
  input  logic               resetN,
  pocket_scheduler_if.slave  bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam int LAST_BALL = NUM_BALLS - 1;
  localparam logic signed [11:0] HOLE_CX_L = 12'(TABLE_LEFT + HOLE_HALF);
  localparam logic signed [11:0] HOLE_CX_M = 12'((TABLE_LEFT + TABLE_RIGHT) / 2 + HOLE_HALF);
  localparam logic signed [11:0] HOLE_CX_R = 12'(TABLE_RIGHT + HOLE_HALF);
  localparam logic signed [11:0] HOLE_CY_T = 12'(TABLE_TOP + HOLE_HALF);
  localparam logic signed [11:0] HOLE_CY_B = 12'(TABLE_BOTTOM + HOLE_HALF);
  localparam logic [23:0]        RADIUS_SQ = 24'(POCKET_R * POCKET_R);

  state_t                  state_q, state_d;
  logic [3:0]              ball_q, ball_d;
  logic [2:0]              hole_q, hole_d;
  logic [11*NUM_BALLS-1:0] x_q, x_d, y_q, y_d;
  logic [NUM_BALLS-1:0]    active_q, active_d;
  logic [NUM_BALLS-1:0]    pocketed_q, pocketed_d;
  logic                    valid_q, valid_d;
  logic [3:0]              pball_q, pball_d;
  logic [2:0]              phole_q, phole_d;
  logic                    done_q, done_d;

  int                      bi;
  logic signed [10:0]      bx, by;
  logic signed [11:0]      hcx, hcy, dx, dy;
  logic signed [22:0]      dx_ext, dy_ext;
  logic [22:0]             dx2, dy2;
  logic [23:0]             dist2;
  logic                    hit;

  // Shared comparator for the pair currently addressed by (ball_q, hole_q).
  always_comb begin
    bi     = int'(ball_q);
    bx     = x_q[11*bi +: 11];
    by     = y_q[11*bi +: 11];
    case (hole_q)
      3'd0, 3'd3: hcx = HOLE_CX_L;
      3'd1, 3'd4: hcx = HOLE_CX_M;
      default:    hcx = HOLE_CX_R;
    endcase
    hcy    = (hole_q < 3'd3) ? HOLE_CY_T : HOLE_CY_B;
    dx     = 12'(bx) + 12'(BALL_HALF) - hcx;
    dy     = 12'(by) + 12'(BALL_HALF) - hcy;
    dx_ext = 23'(dx);
    dy_ext = 23'(dy);
    dx2    = dx_ext * dx_ext;
    dy2    = dy_ext * dy_ext;
    dist2  = {1'b0, dx2} + {1'b0, dy2};
    // The result-register check keeps a second hole of the same ball from re-firing.
    hit    = (state_q == SCAN) && active_q[bi] && (dist2 < RADIUS_SQ)
             && !pocketed_q[bi] && !(valid_q && (pball_q == ball_q));
  end

  always_comb begin
    state_d    = state_q;
    ball_d     = ball_q;
    hole_d     = hole_q;
    x_d        = x_q;
    y_d        = y_q;
    active_d   = active_q;
    valid_d    = hit;
    pball_d    = pball_q;
    phole_d    = phole_q;
    done_d     = 1'b0;
    // Clear first so a set landing on the same edge survives.
    pocketed_d = bus.clearPocketed ? '0 : pocketed_q;
    if (hit) begin
      pball_d        = ball_q;
      phole_d        = hole_q;
      pocketed_d[bi] = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (bus.startOfFrame) begin
          state_d  = SCAN;
          ball_d   = 4'd0;
          hole_d   = 3'd0;
          x_d      = bus.ballsTopLeftX;
          y_d      = bus.ballsTopLeftY;
          active_d = bus.ballsActive;
        end
      end
      SCAN: begin
        if (hole_q == 3'd5) begin
          hole_d = 3'd0;
          if (ball_q == 4'(LAST_BALL)) begin
            state_d = IDLE;
            ball_d  = 4'd0;
            done_d  = 1'b1;
          end else begin
            ball_d = ball_q + 4'd1;
          end
        end else begin
          hole_d = hole_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      ball_q     <= '0;
      hole_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      active_q   <= '0;
      pocketed_q <= '0;
      valid_q    <= 1'b0;
      pball_q    <= '0;
      phole_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ball_q     <= ball_d;
      hole_q     <= hole_d;
      x_q        <= x_d;
      y_q        <= y_d;
      active_q   <= active_d;
      pocketed_q <= pocketed_d;
      valid_q    <= valid_d;
      pball_q    <= pball_d;
      phole_q    <= phole_d;
      done_q     <= done_d;
    end
  end

  assign bus.pocketed    = pocketed_q;
  assign bus.pocketValid = valid_q;
  assign bus.pocketBall  = pball_q;
  assign bus.pocketHole  = phole_q;
  assign bus.busy        = (state_q == SCAN);
  assign bus.frameDone   = done_q;

endmodule
